// File: rtl/stopwatch_display_mux_pkg.sv
// Shared constants for the stopwatch 7-segment display multiplexer.
// Segment/anode encodings are active-low; digit indices follow scan order.
package stopwatch_display_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [1:0] IDX_MIN_T = 2'd0;
  localparam logic [1:0] IDX_MIN_O = 2'd1;
  localparam logic [1:0] IDX_SEC_T = 2'd2;
  localparam logic [1:0] IDX_SEC_O = 2'd3;

  // idx 0 drives an[3], idx 3 drives an[0]
  function automatic logic [3:0] idx_anode(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; dash when out of range.
// Ports: value_i (4b digit), is_tens_i (limit 5 instead of 9), seg_o (7b).
module seven_seg_decoder
  import stopwatch_display_mux_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       is_tens_i,
  output logic [6:0] seg_o
);

  logic in_range;

  always_comb begin
    in_range = is_tens_i ? (value_i <= 4'd5) : (value_i <= 4'd9);
    seg_o    = SEG_DASH;
    if (in_range) begin
      case (value_i)
        4'd0:    seg_o = 7'h40;
        4'd1:    seg_o = 7'h79;
        4'd2:    seg_o = 7'h24;
        4'd3:    seg_o = 7'h30;
        4'd4:    seg_o = 7'h19;
        4'd5:    seg_o = 7'h12;
        4'd6:    seg_o = 7'h02;
        4'd7:    seg_o = 7'h78;
        4'd8:    seg_o = 7'h00;
        4'd9:    seg_o = 7'h10;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Scans four stopwatch BCD digits onto a 4-digit common-anode display.
// Ports: clk, reset, refresh_tick, adjust, sel, digit inputs; an, seg, dp out.
module stopwatch_display_mux
  import stopwatch_display_mux_pkg::*;
#(
  parameter int BLINK_HALF = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       adjust,
  input  logic       sel,
  input  logic [2:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [2:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [1:0]    idx_q, idx_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [2:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0] digit;
  logic       is_tens;
  logic       in_pair;
  logic       blank;
  logic [6:0] dec_seg;

  seven_seg_decoder u_dec (
    .value_i   (digit),
    .is_tens_i (is_tens),
    .seg_o     (dec_seg)
  );

  always_comb begin
    idx_d      = refresh_tick ? idx_q + 2'd1 : idx_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    // min_tens is only shown at idx 0, always from the live input,
    // so it needs no frame register
    if (refresh_tick && idx_d == IDX_MIN_T) begin
      min_ones_d = min_ones;
      sec_tens_d = sec_tens;
      sec_ones_d = sec_ones;
    end

    case (idx_d)
      IDX_MIN_T: digit = {1'b0, min_tens};
      IDX_MIN_O: digit = min_ones_q;
      IDX_SEC_T: digit = {1'b0, sec_tens_q};
      default:   digit = sec_ones_q;
    endcase
    is_tens = ~idx_d[0];

    in_pair = sel ? idx_d[1] : ~idx_d[1];
    blank   = adjust && blink_phase_q && in_pair;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!adjust) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (refresh_tick) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (refresh_tick) begin
      if (blank) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d  = idx_anode(idx_d);
        seg_d = dec_seg;
        dp_d  = (idx_d != IDX_MIN_O);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= IDX_SEC_O;
      min_ones_q    <= '0;
      sec_tens_q    <= '0;
      sec_ones_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      idx_q         <= idx_d;
      min_ones_q    <= min_ones_d;
      sec_tens_q    <= sec_tens_d;
      sec_ones_q    <= sec_ones_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Bench for stopwatch_display_mux: directed scenarios plus random traffic,
// all checked cycle by cycle against a frame/tick-level reference model.
module tb_stopwatch_display_mux;

  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       reset, refresh_tick, adjust, sel;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_ones, sec_ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_idx;
  int         m_frame [4];
  int         m_adj_ticks;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  always #5 clk = ~clk;

  stopwatch_display_mux #(.BLINK_HALF(BH)) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .adjust       (adjust),
    .sel          (sel),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_decode(input int v, input bit tens);
    logic [6:0] glyph [10];
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (tens ? v > 5 : v > 9) return 7'b0111111;
    return glyph[v];
  endfunction

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_edge();
    int nidx;
    bit blank;
    if (reset) begin
      m_idx = 3;
      for (int i = 0; i < 4; i++) m_frame[i] = 0;
      m_adj_ticks = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      return;
    end
    if (refresh_tick) begin
      nidx  = (m_idx + 1) % 4;
      blank = adjust && ((m_adj_ticks / BH) % 2 == 1) &&
              (sel ? nidx >= 2 : nidx < 2);
      if (nidx == 0) begin
        m_frame[0] = int'(min_tens);
        m_frame[1] = int'(min_ones);
        m_frame[2] = int'(sec_tens);
        m_frame[3] = int'(sec_ones);
      end
      if (blank) begin
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_an = 4'hF;
        m_an[3-nidx] = 1'b0;
        m_seg = m_decode(m_frame[nidx], nidx % 2 == 0);
        m_dp  = (nidx != 1);
      end
      m_idx = nidx;
    end
    if (!adjust) m_adj_ticks = 0;
    else if (refresh_tick) m_adj_ticks = (m_adj_ticks + 1) % (2 * BH);
  endtask

  task automatic step(input logic r, input logic t);
    reset = r;
    refresh_tick = t;
    model_edge();
    @(posedge clk);
    #1;
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
    chk("dp", dp, m_dp);
  endtask

  task automatic set_digits(input int mt, input int mo, input int st, input int so);
    min_tens = 3'(mt); min_ones = 4'(mo);
    sec_tens = 3'(st); sec_ones = 4'(so);
  endtask

  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];
  int         blanked_sec;

  initial begin
    exp_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    adjust = 1'b0; sel = 1'b0;
    set_digits(1, 2, 3, 4);

    // 1: reset, blank until first tick, then 1,2,3,4 in scan order
    step(1, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    step(0, 0);
    chk("pre_tick_an", an, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step(0, 1);
      chk("t1_an", an, exp_an[i]);
      chk("t1_seg", seg, exp_seg[i]);
      chk("t1_dp", dp, exp_dp[i]);
      step(0, 0);
    end

    // 2: mid-frame change is invisible until the next frame
    step(0, 1);
    step(0, 1);
    sec_ones = 4'd9;
    step(0, 1);
    step(0, 1);
    chk("t2_old_seg", seg, 7'h19);
    for (int i = 0; i < 4; i++) step(0, 1);
    chk("t2_new_seg", seg, 7'h10);

    // 3: out-of-range digits decode to a dash
    set_digits(5, 12, 7, 0);
    step(0, 1);
    step(0, 1);
    chk("t3_ones_dash", seg, 7'h3F);
    step(0, 1);
    chk("t3_tens_dash", seg, 7'h3F);
    step(0, 1);
    set_digits(1, 2, 3, 4);

    // 4: blink the seconds pair
    adjust = 1'b1; sel = 1'b1;
    blanked_sec = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 1);
      if (an == 4'hF) blanked_sec++;
    end
    chk("t4_blank_count", blanked_sec, 6);
    adjust = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1);
      chk("t4_no_blank", an == 4'hF, 1'b0);
    end
    adjust = 1'b1; sel = 1'b0;
    for (int i = 0; i < 16; i++) step(0, (i % 3) != 2);
    adjust = 1'b0;

    // 5: reset together with a tick mid-frame
    step(0, 1);
    step(1, 1);
    chk("t5_rst_an", an, 4'hF);
    step(0, 0);
    step(0, 1);
    chk("t5_first_an", an, 4'b0111);

    // 6: tick held high for three cycles after reset
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      chk("t6_an", an, exp_an[i]);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) adjust = ~adjust;
      if ($urandom_range(0, 99) < 5) sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 9) == 0)
          set_digits($urandom_range(0, 7), $urandom_range(0, 15),
                     $urandom_range(0, 7), $urandom_range(0, 15));
        else
          set_digits($urandom_range(0, 5), $urandom_range(0, 9),
                     $urandom_range(0, 5), $urandom_range(0, 9));
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
